mul8u_share_arb: RTL

- Shares one 8x8 unsigned approximate multiplier core (combinational; A[7:0], B[7:0] -> O[15:0]) among NREQ requesters.
- Requesters are served in round-robin order.
- The block registers operands in front of the core and the product behind it, then returns each result to the requester that issued it through a valid/ready response.
- The core sits outside the block, connected through the mul_* ports, so approximate variants can be swapped without touching the arbiter.

---
 rtl/mul8u_share_pkg.sv | 43 ++++
 rtl/mul8u_share_arb_rr.sv | 41 ++++
 rtl/mul8u_share_arb.sv | 115 +++++++++++
 3 files changed

// File: rtl/mul8u_share_pkg.sv
// rtl/mul8u_share_pkg.sv - shared types and round-robin pick helper for the multiplier-sharing arbiter
package mul8u_share_pkg;

  localparam int MUL_W    = 8;
  localparam int PROD_W   = 16;
  localparam int MAX_REQ  = 8;
  localparam int ID_MAX_W = 3;

  typedef struct packed {
    logic                valid;
    logic [ID_MAX_W-1:0] id;
    logic [MUL_W-1:0]    a;
    logic [MUL_W-1:0]    b;
  } s1_entry_t;

  typedef struct packed {
    logic                valid;
    logic [ID_MAX_W-1:0] id;
    logic [PROD_W-1:0]   prod;
  } s2_entry_t;

  // Returns {found, index}: the requester nearest to ptr going upward, wrapping modulo n.
  function automatic logic [ID_MAX_W:0] rr_pick(input logic [MAX_REQ-1:0]  req,
                                                input logic [ID_MAX_W-1:0] ptr,
                                                input int                  n);
    logic [ID_MAX_W:0] pick;
    int                best_d;
    int                d;
    pick   = '0;
    best_d = MAX_REQ;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (i < n && req[i]) begin
        d = (i >= int'(ptr)) ? i - int'(ptr) : i + n - int'(ptr);
        if (d < best_d) begin
          best_d = d;
          pick   = {1'b1, ID_MAX_W'(i)};
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/mul8u_share_arb_rr.sv
// rtl/mul8u_share_arb_rr.sv - NREQ-wide combinational round-robin picker
module rr_arbiter_n
  import mul8u_share_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  input  logic            en,
  output logic [NREQ-1:0] grant_onehot,
  output logic [ID_W-1:0] grant_id,
  output logic            any
);

  logic [MAX_REQ-1:0]  w_req;
  logic [ID_MAX_W-1:0] w_ptr;
  logic [ID_MAX_W:0]   w_pick;
  logic [NREQ-1:0]     w_oh_raw;

  always_comb begin
    w_req             = '0;
    w_req[NREQ-1:0]   = req;
    w_ptr             = '0;
    w_ptr[ID_W-1:0]   = ptr;
  end

  assign w_pick   = rr_pick(w_req, w_ptr, NREQ);
  assign any      = w_pick[ID_MAX_W];
  assign w_oh_raw = w_pick[ID_MAX_W] ? (NREQ'(1) << w_pick[ID_MAX_W-1:0]) : '0;

  always_comb begin
    grant_id = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_oh_raw[i]) grant_id = ID_W'(i);
    end
  end

  assign grant_onehot = en ? w_oh_raw : '0;

endmodule

// File: rtl/mul8u_share_arb.sv
// rtl/mul8u_share_arb.sv - shares one external 8x8 multiplier core among NREQ requesters
// through a two-stage operand/product pipeline with per-requester valid/ready responses.
module mul8u_share_arb
  import mul8u_share_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int ID_W  = 2,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*MUL_W-1:0]   req_a,
  input  logic [NREQ*MUL_W-1:0]   req_b,
  output logic [NREQ-1:0]         resp_valid,
  input  logic [NREQ-1:0]         resp_ready,
  output logic [PROD_W-1:0]       resp_data,
  output logic [MUL_W-1:0]        mul_a,
  output logic [MUL_W-1:0]        mul_b,
  input  logic [PROD_W-1:0]       mul_o,
  output logic [CNT_W-1:0]        ops_done,
  output logic                    idle
);

  s1_entry_t       r_s1;
  s2_entry_t       r_s2;
  logic [ID_W-1:0] r_rr;
  logic [CNT_W-1:0] r_ops_done;

  logic [NREQ-1:0] w_s2_sel;
  logic [NREQ-1:0] w_grant_oh;
  logic [ID_W-1:0] w_grant_id;
  logic [MUL_W-1:0] w_a;
  logic [MUL_W-1:0] w_b;
  logic            w_any;
  logic            w_resp_fire;
  logic            w_s2_adv;
  logic            w_s1_adv;
  logic            w_accept;

  always_comb begin
    w_s2_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_s2_sel[i] = r_s2.valid && (r_s2.id == ID_MAX_W'(i));
    end
  end

  assign w_resp_fire = |(w_s2_sel & resp_ready);
  assign w_s2_adv    = !r_s2.valid || w_resp_fire;
  assign w_s1_adv    = !r_s1.valid || w_s2_adv;

  // Grants are suppressed while reset is held so no requester sees a spurious accept.
  rr_arbiter_n #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_arb (
    .req          (req_valid),
    .ptr          (r_rr),
    .en           (w_s1_adv && rst_n),
    .grant_onehot (w_grant_oh),
    .grant_id     (w_grant_id),
    .any          (w_any)
  );

  assign w_accept = |w_grant_oh;

  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant_oh[i]) begin
        w_a = req_a[MUL_W*i +: MUL_W];
        w_b = req_b[MUL_W*i +: MUL_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1       <= '0;
      r_s2       <= '0;
      r_rr       <= '0;
      r_ops_done <= '0;
    end else begin
      if (w_s1_adv) begin
        if (w_accept) begin
          r_s1 <= '{valid: 1'b1, id: ID_MAX_W'(w_grant_id), a: w_a, b: w_b};
          r_rr <= (w_grant_id == ID_W'(NREQ-1)) ? '0 : w_grant_id + 1'b1;
        end else begin
          r_s1.valid <= 1'b0;
        end
      end
      if (w_s2_adv) begin
        if (r_s1.valid) begin
          r_s2 <= '{valid: 1'b1, id: r_s1.id, prod: mul_o};
        end else begin
          r_s2.valid <= 1'b0;
        end
      end
      if (w_resp_fire) begin
        r_ops_done <= r_ops_done + 1'b1;
      end
    end
  end

  assign req_ready  = w_grant_oh;
  assign resp_valid = w_s2_sel;
  assign resp_data  = r_s2.prod;
  assign mul_a      = r_s1.a;
  assign mul_b      = r_s1.b;
  assign ops_done   = r_ops_done;
  assign idle       = !rst_n || (!w_any && !r_s1.valid && !r_s2.valid);

endmodule
